adpt_quan_pipe: RTL and testbench
=================================

ADPT_QUAN_PIPE -- requirements
Module: adpt_quan_pipe

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, giving the signed sample width.
REQ-002 The block SHALL expose parameter CODE_W, default 4, giving the sign-magnitude code width (QMAX = 2^(CODE_W-1)-1).
REQ-003 The block SHALL expose parameter NUM_CH, default 2, giving the number of independent channels (CH_W = max(1, clog2(NUM_CH))).
REQ-004 The block SHALL expose parameters EXP_INIT, EXP_MIN and EXP_MAX, defaults 4, 0 and 11, giving the step exponent (step = 2^exp).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be as follows:
  clk  in  1  clock.
  reset  in  1  synchronous active-high reset.
  in_valid  in  1  sample offered.
  in_ready  out  1  sample accepted when in_valid && in_ready.
  in_sample  in  DATA_W  signed input sample.
  in_ch  in  CH_W  channel index.
  cfg_bypass  in  1  pass-through mode.
  ch_clr  in  1  pulse that reinitialises all exponents.
  out_valid  out  1  result present.
  out_ready  in  1  result consumed when out_valid && out_ready.
  out_code  out  CODE_W  {sign, q}.
  out_rec  out  DATA_W  signed reconstructed sample.
  out_ch  out  CH_W  channel of the result.
  out_exp  out  4  exponent used for this sample.

Function
REQ-007 On acceptance, the block SHALL compute mag = |in_sample| (DATA_W-bit unsigned, so that -2^(DATA_W-1) is handled exactly), q = min(mag >> exp[in_ch], QMAX), and sign = in_sample < 0.
REQ-008 On the same acceptance edge, exp[in_ch] SHALL be updated: if q == QMAX, increment it, saturating at EXP_MAX; if q == 0, decrement it, saturating at EXP_MIN; otherwise hold it.
REQ-009 Exponents of other channels SHALL NOT change, so back-to-back samples on the same channel see the updated exponent with no hazard.
REQ-010 Reconstruction SHALL be computed as follows: if q == 0, rec = 0.
REQ-011 Otherwise, rec = (q << exp) + (exp > 0 ? 2^(exp-1) : 0), negated if sign is set, then saturated to the signed DATA_W range.
REQ-012 The block SHALL form a two-stage pipeline: stage 1 (quantise + adapt) and stage 2 (reconstruct).
REQ-013 out_valid SHALL assert exactly 2 cycles after acceptance when out_ready is held high.
REQ-014 Stall rule: en = !out_valid || out_ready, and both stages SHALL advance only when en is high; in_ready = en.
REQ-015 Under stall, no result SHALL be lost, duplicated or reordered.
REQ-016 Full throughput SHALL be one sample per cycle.
REQ-017 In bypass mode (cfg_bypass sampled at acceptance), out_rec SHALL equal in_sample, out_code SHALL be 0, and exp SHALL NOT be updated.
REQ-018 In bypass mode, out_exp SHALL report the current exp[in_ch].
REQ-019 ch_clr SHALL set every exp to EXP_INIT on the next edge.
REQ-020 If ch_clr coincides with acceptance, the accepted sample SHALL be quantised with the pre-clear exponent, and the clear SHALL take priority over its update.
REQ-021 An in_ch value >= NUM_CH SHALL be treated as channel 0.
REQ-022 out_code, out_rec, out_ch and out_exp SHALL be held stable while out_valid && !out_ready.

Reset
REQ-023 While reset is high, out_valid and the internal stage-valid bits SHALL be 0, all data outputs SHALL be 0, and every exp SHALL be EXP_INIT.
REQ-024 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight samples, with no output appearing afterwards for those samples.

Structure
REQ-026 A shared package adpt_quan_pkg SHALL hold the default widths, the QMAX function, EXP_INIT/MIN/MAX defaults and the stage-1 payload struct {code, exp, ch, bypass, sample}.
REQ-027 Reconstruction SHALL be a sub-module adpt_iquan (combinational: code, exp -> saturated rec), instanced in stage 2.
REQ-028 The exponent table SHALL be NUM_CH registers; no RAM SHALL be inferred.

Verification
REQ-029 Scenario: reset, then ch0 sample +100 -> 2 cycles later out_code=4'b0110, out_rec=104, out_exp=4; exp0 remains 4.
REQ-030 Scenario: ch0 sample -32768 -> out_code=4'b1111, out_rec=-120, exp0 becomes 5; 7 more such samples -> exp0 saturates at 11, and the final out_rec = -(7*2048+1024) = -15360.
REQ-031 Scenario: ch1 sample 0 repeated 6 times -> out_rec=0 each time, exp1 steps 4,3,2,1,0,0; exp0 unchanged throughout.
REQ-032 Scenario: continuous in_valid with out_ready low for 5 cycles mid-stream -> in_ready drops within 1 cycle, and the output sequence equals the input sequence with no gaps, drops or duplicates.
REQ-033 Scenario: cfg_bypass=1 with sample -7 -> out_rec=-7, out_code=0, exp unchanged; ch_clr after exp0 reaches 9 -> exp0=4 on the next sample.
REQ-034 Scenario: reset asserted with 2 samples in flight -> out_valid=0 next cycle, and no stale output appears after reset releases.

Source files
------------

// File: rtl/adpt_quan_pkg.sv
// Shared defaults, the code-range helper and the stage-1 payload for the adaptive quantiser.
package adpt_quan_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int CODE_W_DEF   = 4;
  localparam int NUM_CH_DEF   = 2;
  localparam int EXP_INIT_DEF = 4;
  localparam int EXP_MIN_DEF  = 0;
  localparam int EXP_MAX_DEF  = 11;
  localparam int EXP_W        = 4;

  // Payload fields are sized for the widest supported configuration; the
  // pipeline only reads back the low bits that match its own parameters.
  localparam int PL_DATA_W = 32;
  localparam int PL_CODE_W = 8;
  localparam int PL_CH_W   = 8;

  // Largest magnitude expressible by a sign-magnitude code of code_w bits.
  function automatic int qmax(input int code_w);
    return (1 << (code_w - 1)) - 1;
  endfunction

  typedef struct packed {
    logic [PL_CODE_W-1:0] code;
    logic [EXP_W-1:0]     exp;
    logic [PL_CH_W-1:0]   ch;
    logic                 bypass;
    logic [PL_DATA_W-1:0] sample;
  } s1_pl_t;
endpackage

// File: rtl/adpt_iquan.sv
// Inverse quantiser: sign-magnitude code plus step exponent to a saturated signed sample.
module adpt_iquan
  import adpt_quan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [CODE_W-1:0] code,
  input  logic [EXP_W-1:0]  exp,
  output logic [DATA_W-1:0] rec
);
  localparam logic [31:0] POS_LIM = (32'd1 << (DATA_W - 1)) - 32'd1;

  logic [CODE_W-2:0] q;
  logic              sign;
  logic [31:0]       mag;
  logic [31:0]       neg;

  // Mid-step reconstruction, then clamp into the signed DATA_W range.
  always_comb begin
    q    = code[CODE_W-2:0];
    sign = code[CODE_W-1];
    mag  = (32'(q) << exp) + ((exp != '0) ? (32'd1 << (exp - 4'd1)) : 32'd0);
    neg  = 32'd0 - mag;
    if (q == '0)
      rec = '0;
    else if (!sign)
      rec = (mag > POS_LIM) ? POS_LIM[DATA_W-1:0] : mag[DATA_W-1:0];
    else
      rec = (mag > POS_LIM + 32'd1) ? {1'b1, {(DATA_W-1){1'b0}}} : neg[DATA_W-1:0];
  end
endmodule

// File: rtl/adpt_quan_pipe.sv
// Two-stage adaptive quantiser: stage 1 quantises and adapts the per-channel
// exponent, stage 2 reconstructs. Both stages share one stall enable.
module adpt_quan_pipe
  import adpt_quan_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int EXP_INIT = EXP_INIT_DEF,
  parameter int EXP_MIN  = EXP_MIN_DEF,
  parameter int EXP_MAX  = EXP_MAX_DEF,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              cfg_bypass,
  input  logic              ch_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_rec,
  output logic [CH_W-1:0]   out_ch,
  output logic [3:0]        out_exp
);
  localparam int               QMAX   = qmax(CODE_W);
  localparam logic [EXP_W-1:0] E_INIT = EXP_W'(EXP_INIT);
  localparam logic [EXP_W-1:0] E_MIN  = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] E_MAX  = EXP_W'(EXP_MAX);

  logic              en, acc;
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  s1_pl_t            pl_q, pl_d;
  logic [EXP_W-1:0]  exp_q [NUM_CH];
  logic [EXP_W-1:0]  exp_d [NUM_CH];
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [DATA_W-1:0] out_rec_q, out_rec_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;

  logic [CH_W-1:0]   ch_sel;
  logic [EXP_W-1:0]  cur_exp;
  logic [DATA_W-1:0] mag, shifted;
  logic [CODE_W-2:0] q;
  logic              sign;
  logic [DATA_W-1:0] iq_rec;
  logic              unused_pl;

  assign en        = !vld_pipe_q[1] || out_ready;
  assign acc       = in_valid && en;
  assign in_ready  = en;
  assign out_valid = vld_pipe_q[1];
  assign out_code  = out_code_q;
  assign out_rec   = out_rec_q;
  assign out_ch    = out_ch_q;
  assign out_exp   = out_exp_q;
  assign unused_pl = ^pl_q;

  // Quantise: unsigned magnitude keeps the most negative sample exact.
  always_comb begin
    ch_sel  = (int'(in_ch) < NUM_CH) ? in_ch : '0;
    cur_exp = exp_q[ch_sel];
    sign    = in_sample[DATA_W-1];
    mag     = sign ? (~in_sample) + DATA_W'(1) : in_sample;
    shifted = mag >> cur_exp;
    q       = (shifted > DATA_W'(QMAX)) ? (CODE_W-1)'(QMAX) : shifted[CODE_W-2:0];
  end

  // Exponent adaptation; a clear overrides any same-edge update.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) exp_d[i] = exp_q[i];
    if (acc && !cfg_bypass) begin
      if (q == (CODE_W-1)'(QMAX))
        exp_d[ch_sel] = (cur_exp < E_MAX) ? cur_exp + EXP_W'(1) : cur_exp;
      else if (q == '0)
        exp_d[ch_sel] = (cur_exp > E_MIN) ? cur_exp - EXP_W'(1) : cur_exp;
    end
    if (ch_clr)
      for (int i = 0; i < NUM_CH; i++) exp_d[i] = E_INIT;
  end

  // Stage-1 payload and the valid shift register, both gated by the stall enable.
  always_comb begin
    pl_d       = pl_q;
    vld_pipe_d = vld_pipe_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[0], acc};
      if (acc) begin
        pl_d.code   = cfg_bypass ? '0 : PL_CODE_W'({sign, q});
        pl_d.exp    = cur_exp;
        pl_d.ch     = PL_CH_W'(ch_sel);
        pl_d.bypass = cfg_bypass;
        pl_d.sample = PL_DATA_W'(in_sample);
      end
    end
  end

  adpt_iquan #(.DATA_W(DATA_W), .CODE_W(CODE_W)) u_iquan (
    .code (pl_q.code[CODE_W-1:0]),
    .exp  (pl_q.exp),
    .rec  (iq_rec)
  );

  // Stage-2 output registers; held while the consumer stalls.
  always_comb begin
    out_code_d = out_code_q;
    out_rec_d  = out_rec_q;
    out_ch_d   = out_ch_q;
    out_exp_d  = out_exp_q;
    if (en && vld_pipe_q[0]) begin
      out_code_d = pl_q.code[CODE_W-1:0];
      out_rec_d  = pl_q.bypass ? pl_q.sample[DATA_W-1:0] : iq_rec;
      out_ch_d   = pl_q.ch[CH_W-1:0];
      out_exp_d  = pl_q.exp;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      pl_q       <= '0;
      out_code_q <= '0;
      out_rec_q  <= '0;
      out_ch_q   <= '0;
      out_exp_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) exp_q[i] <= E_INIT;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pl_q       <= pl_d;
      out_code_q <= out_code_d;
      out_rec_q  <= out_rec_d;
      out_ch_q   <= out_ch_d;
      out_exp_q  <= out_exp_d;
      for (int i = 0; i < NUM_CH; i++) exp_q[i] <= exp_d[i];
    end
  end
endmodule

// File: tb/tb_adpt_quan_pipe.sv
// Directed bench for adpt_quan_pipe with hand-computed expectations and an in-order scoreboard.
module tb_adpt_quan_pipe;
  logic        clk = 0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_sample;
  logic [0:0]  in_ch;
  logic        cfg_bypass, ch_clr;
  logic        out_valid, out_ready;
  logic [3:0]  out_code;
  logic [15:0] out_rec;
  logic [0:0]  out_ch;
  logic [3:0]  out_exp;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int code; int rec; int ch; int ex; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  adpt_quan_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_ch(in_ch), .cfg_bypass(cfg_bypass), .ch_clr(ch_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_rec(out_rec), .out_ch(out_ch), .out_exp(out_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, req);
    end
  endtask

  // Drive one sample, wait for acceptance, and queue its expected result.
  task automatic send(input int s, input int ch, input bit byp, input bit clr, input bit push,
                      input int ecode, input int erec, input int eexp);
    bit ok = 0;
    in_valid = 1; in_sample = 16'(s); in_ch = 1'(ch); cfg_bypass = byp; ch_clr = clr;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (push) sbq.push_back('{ecode, erec, ch, eexp});
    @(posedge clk); #1;
    in_valid = 0; cfg_bypass = 0; ch_clr = 0;
  endtask

  // Output monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("out_code", int'(out_code), mon_e.code);
        chk("out_rec", int'($signed(out_rec)), mon_e.rec);
        chk("out_ch", int'(out_ch), mon_e.ch);
        chk("out_exp", int'(out_exp), mon_e.ex);
      end
    end
  end

  int stall_vals[10] = '{1, 2, -3, 4, 5, 6, -1, 2, 3, 4};
  int stall_code[10] = '{1, 2, 11, 4, 5, 6, 9, 2, 3, 4};
  int held;

  initial begin
    reset = 1; in_valid = 0; in_sample = 0; in_ch = 0;
    cfg_bypass = 0; ch_clr = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_code", int'(out_code), 0);
    chk("rst_rec", int'(out_rec), 0);
    chk("rst_exp", int'(out_exp), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rdy_after_rst", int'(in_ready), 1);
    @(posedge clk); #1;

    // +100 at exp 4: q=6, rec=96+8, exp holds; check 2-cycle latency
    send(100, 0, 0, 0, 1, 6, 104, 4);
    @(negedge clk); chk("lat_cyc1", int'(out_valid), 0);
    @(negedge clk); chk("lat_cyc2", int'(out_valid), 1);
    @(posedge clk); #1;

    // full-scale negative: q=7 each time, exp climbs 4..11 then saturates
    for (int k = 0; k < 8; k++)
      send(-32768, 0, 0, 0, 1, 15, -((7 << (4 + k)) + (1 << (3 + k))), 4 + k);

    // zeros on ch1 walk its exponent down to the floor
    send(0, 1, 0, 0, 1, 0, 0, 4);
    send(0, 1, 0, 0, 1, 0, 0, 3);
    send(0, 1, 0, 0, 1, 0, 0, 2);
    send(0, 1, 0, 0, 1, 0, 0, 1);
    send(0, 1, 0, 0, 1, 0, 0, 0);
    send(0, 1, 0, 0, 1, 0, 0, 0);

    // ch0 still saturated at 11: 100>>11 = 0, exp drops to 10
    send(100, 0, 0, 0, 1, 0, 0, 11);

    // streaming on ch1 (exp 0) with a 5-cycle consumer stall mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(stall_vals[i], 1, 0, 0, 1, stall_code[i], stall_vals[i], 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("stall_in_ready", int'(in_ready), 0);
        held = int'($signed(out_rec));
        repeat (4) begin
          @(negedge clk);
          chk("stall_hold_rec", int'($signed(out_rec)), held);
          chk("stall_hold_vld", int'(out_valid), 1);
        end
        @(posedge clk); #1 out_ready = 1;
      end
    join

    // bypass leaves exp0 at 10 and passes the sample through
    send(-7, 0, 1, 0, 1, 0, -7, 10);
    send(0, 0, 0, 0, 1, 0, 0, 10);
    // exp0 now 9; a lone clear restores 4
    ch_clr = 1; @(posedge clk); #1 ch_clr = 0;
    send(100, 0, 0, 0, 1, 6, 104, 4);
    // clear coinciding with acceptance: old exp used, clear wins over increment
    send(-32768, 0, 0, 1, 1, 15, -120, 4);
    send(100, 0, 0, 0, 1, 6, 104, 4);

    repeat (6) @(posedge clk); #1;

    // reset with two samples in flight; nothing from them may surface
    send(-32768, 0, 0, 0, 0, 0, 0, 0);
    send(-32768, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_rec", int'(out_rec), 0);
    chk("midrst_code", int'(out_code), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("midrst_rdy", int'(in_ready), 1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    // exponent back at its initial value
    send(100, 0, 0, 0, 1, 6, 104, 4);

    for (int k = 0; k < 50 && sbq.size() > 0; k++) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
